tx_scheduler: RTL and testbench
===============================

Name: tx_scheduler

Overview:
- Decides which outbound packet the node sends next, and when.
- Latches transmit requests from packet reception, role changes and internal timers, and arbitrates them by fixed priority.
- Drives the reward packer (en/type/neighbor index) and waits for its done signal.
- Then holds the packed frame for the MAC/transmit interface until that interface accepts it.

Parameters:
- WORD_WIDTH, 16, width of hop/ID fields.
- MR_TIMEOUT, 15, cycles from first accepted INV to Membership Request.
- CHT_TIMEOUT, 15, cycles from own INV transmit to CH Timeslot burst.
- INV_HOP_LIMIT, 4, INV is rippled only if hopsFromCH < this.
- IDX_W, 6, neighbor index width (max 63 neighbors).

Ports:
- clk, in, 1, clock.
- nrst, in, 1, async active-low reset.
- rx_valid, in, 1, one-cycle strobe: filtered packet available.
- fPacketType, in, 3, received packet type (HB 000, CHE 001, INV 010, MR 011, CHT 100, Data 101, SOS 110).
- iAmDestination, in, 1, received Data/SOS is addressed to this node.
- hopsFromCH, in, WORD_WIDTH, hop field of received INV.
- role, in, 1, 1 = cluster head.
- low_E, in, 1, energy below threshold.
- iHaveData, in, 1, level: own sensor data waiting.
- neighborCount, in, IDX_W, valid neighbor table entries.
- pack_en, out, 1, one-cycle start pulse to packer.
- pack_type, out, 3, packet type to pack (111 = none).
- pack_index, out, IDX_W, neighbor-table index for CHT packing.
- pack_done, in, 1, packer finished.
- tx_valid, out, 1, frame ready for transmit.
- tx_ready, in, 1, transmitter accepts the frame.
- HBLock, out, 1, heartbeat already rippled this round.
- busy, out, 1, state != IDLE.

Behaviour:
- Reset (async, nrst=0) values:
  - Outputs: pack_en=0, pack_type=3'b111, pack_index=0, tx_valid=0, HBLock=0, busy=0.
  - Internal: all pending flags 0, both timers idle, state IDLE.
- Pending flags are set on the cycle after their event. A set and a clear (grant) of the same flag in the same cycle leaves it set. Repeat events while a flag is pending coalesce into one request.
- Flag set conditions:
  - HB: rx_valid && type 000 && !HBLock; also sets HBLock.
  - Data rx (rx_valid && type 101) clears HBLock.
  - INVR: rx_valid && type 010 && hopsFromCH < INV_HOP_LIMIT && !role.
  - INVO: rising edge of role.
  - MR timer: loads MR_TIMEOUT on the first accepted INV while !role and MR timer is idle. Decrements each cycle. Reaching 0 sets MR and the timer returns to idle.
  - CHT timer: loads CHT_TIMEOUT on completion of the INVO transmit. Reaching 0 sets CHT.
  - SOS: rx_valid && type 110 && iAmDestination, or a rising edge of low_E.
  - FWD: rx_valid && type 101 && iAmDestination.
  - OWN: iHaveData level, sampled only in IDLE.
- Priority, highest first: HB, INVR, INVO, CHT, MR, SOS, FWD, OWN.
- FSM:
  - IDLE: if any flag is set, latch the winner into pack_type, clear its flag, set pack_index=0, go to PACK. Otherwise stay.
  - PACK: pack_en=1 for exactly one cycle, then go to WAIT.
  - WAIT: hold pack_type. On pack_done go to TX. pack_done outside WAIT is ignored.
  - TX: tx_valid=1 until tx_ready.
    - On the handshake, if pack_type==CHT and pack_index+1 < neighborCount: pack_index++ and go to PACK.
    - Otherwise go to IDLE with pack_type=111.
- Latency: event at cycle N gives flag at N+1, pack_en at N+2 (assuming IDLE and highest priority).
- CHT with neighborCount==0: the grant is consumed, no pack_en is issued, return to IDLE.
- role falling while in IDLE clears INVO/CHT flags and the CHT timer. An in-flight packet always completes.
- rx events during non-IDLE states are still latched as flags.

Decomposition:
- Package tx_pkg holds:
  - pkt_type_e enum (HB..SOS, NONE=111).
  - sched_state_e (IDLE, PACK, WAIT, TX).
  - Priority order constant.
- Sub-module tx_countdown (load, dec, zero pulse), instantiated twice for the MR and CHT timers.

Test Plan:
- rx HB (000), HBLock=0: pack_type=000, pack_en at N+2; HBLock=1. A second HB produces no packet. Data rx clears HBLock, and the next HB is packed.
- rx INV with hopsFromCH=3: packet type 010 sent. hopsFromCH=4: none. Exactly 15 cycles after the first accepted INV, MR (011) is packed.
- role 0→1: INV (010) sent. After its tx handshake plus 15 cycles, the CHT burst with neighborCount=3 gives pack_index 0,1,2 and three tx handshakes, then IDLE.
- HB, FWD and SOS flags all pending simultaneously: order is HB, SOS, FWD; each flag is cleared once.
- tx_ready held low 20 cycles: tx_valid stays 1 and pack_type stable. With neighborCount=0 the CHT grant produces no pack_en.
- nrst asserted in WAIT during a CHT burst: all outputs reset immediately, flags cleared, no pack_en after release.

Source files
------------

// File: rtl/tx_pkg.sv
// tx_pkg: shared types for the transmit scheduler.
// Packet types, FSM states, request sources, priority order.
package tx_pkg;

  typedef enum logic [2:0] {
    PKT_HB   = 3'b000,
    PKT_CHE  = 3'b001,
    PKT_INV  = 3'b010,
    PKT_MR   = 3'b011,
    PKT_CHT  = 3'b100,
    PKT_DATA = 3'b101,
    PKT_SOS  = 3'b110,
    PKT_NONE = 3'b111
  } pkt_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PACK,
    ST_WAIT,
    ST_TX
  } sched_state_e;

  // Request sources; OWN has no latched flag
  typedef enum logic [2:0] {
    SRC_HB,
    SRC_INVR,
    SRC_INVO,
    SRC_CHT,
    SRC_MR,
    SRC_SOS,
    SRC_FWD,
    SRC_OWN
  } src_e;

  localparam int NSRC  = 8;
  localparam int NFLAG = 7;

  // Highest priority first
  localparam src_e PRIO_ORDER [NSRC] = '{
    SRC_HB, SRC_INVR, SRC_INVO, SRC_CHT,
    SRC_MR, SRC_SOS, SRC_FWD, SRC_OWN
  };

  function automatic src_e pick_src(
    input logic [NSRC-1:0] req
  );
    src_e w;
    w = SRC_OWN;
    for (int i = NSRC-1; i >= 0; i--)
      if (req[PRIO_ORDER[i]]) w = PRIO_ORDER[i];
    return w;
  endfunction

  function automatic pkt_type_e src_type(
    input src_e s
  );
    pkt_type_e t;
    unique case (s)
      SRC_HB:   t = PKT_HB;
      SRC_INVR: t = PKT_INV;
      SRC_INVO: t = PKT_INV;
      SRC_CHT:  t = PKT_CHT;
      SRC_MR:   t = PKT_MR;
      SRC_SOS:  t = PKT_SOS;
      default:  t = PKT_DATA;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tx_countdown.sv
// tx_countdown: one-shot down-counter, pulses zero_o on expiry.
// Ports: clk, nrst, load_i (start at T), clr_i (abort), zero_o, active_o.
module tx_countdown #(
  parameter int T = 15
) (
  input  logic clk,
  input  logic nrst,
  input  logic load_i,
  input  logic clr_i,
  output logic zero_o,
  output logic active_o
);

  localparam int W = $clog2(T + 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         act_q, act_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
      act_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      act_q <= act_d;
    end
  end

  // zero_o fires on the cycle the count steps 1 -> 0
  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    zero_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
      act_d = 1'b0;
    end else if (load_i) begin
      cnt_d = W'(T);
      act_d = 1'b1;
    end else if (act_q) begin
      if (cnt_q == W'(1)) begin
        zero_o = 1'b1;
        act_d  = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q - W'(1);
      end
    end
  end

  assign active_o = act_q;

endmodule

// File: rtl/tx_scheduler.sv
// tx_scheduler: latches transmit requests, arbitrates by priority,
// drives the packer (pack_en/type/index) and holds tx_valid to handshake.
// In: rx_valid/fPacketType/iAmDestination/hopsFromCH, role, low_E,
//   iHaveData, neighborCount, pack_done, tx_ready.
// Out: pack_en, pack_type, pack_index, tx_valid, HBLock, busy.
module tx_scheduler
  import tx_pkg::*;
#(
  parameter int WORD_WIDTH    = 16,
  parameter int MR_TIMEOUT    = 15,
  parameter int CHT_TIMEOUT   = 15,
  parameter int INV_HOP_LIMIT = 4,
  parameter int IDX_W         = 6
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  rx_valid,
  input  logic [2:0]            fPacketType,
  input  logic                  iAmDestination,
  input  logic [WORD_WIDTH-1:0] hopsFromCH,
  input  logic                  role,
  input  logic                  low_E,
  input  logic                  iHaveData,
  input  logic [IDX_W-1:0]      neighborCount,
  output logic                  pack_en,
  output logic [2:0]            pack_type,
  output logic [IDX_W-1:0]      pack_index,
  input  logic                  pack_done,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  HBLock,
  output logic                  busy
);

  sched_state_e          state_q, state_d;
  pkt_type_e             type_q, type_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  src_e                  src_q, src_d;
  logic [NFLAG-1:0]      flag_q, flag_d;
  logic [NFLAG-1:0]      set_v, clr_v;
  logic                  hbl_q, hbl_d;
  logic                  role_q, lowe_q;

  logic                  rx_hb, rx_data, rx_sos;
  logic                  inv_ok;
  logic                  role_rise, role_fall;
  logic                  idle_fall;
  logic                  mr_zero, mr_act;
  logic                  cht_zero, cht_act;
  logic                  cht_load;
  logic [NSRC-1:0]       req;
  src_e                  win;
  logic                  nxt_cht;

  assign rx_hb   = rx_valid && (fPacketType == PKT_HB);
  assign rx_data = rx_valid && (fPacketType == PKT_DATA);
  assign rx_sos  = rx_valid && (fPacketType == PKT_SOS);
  assign inv_ok  = rx_valid && (fPacketType == PKT_INV)
                && (hopsFromCH < WORD_WIDTH'(INV_HOP_LIMIT))
                && !role;

  assign role_rise = role && !role_q;
  assign role_fall = !role && role_q;
  assign idle_fall = role_fall && (state_q == ST_IDLE);

  tx_countdown #(.T(MR_TIMEOUT)) u_mr (
    .clk      (clk),
    .nrst     (nrst),
    .load_i   (inv_ok && !mr_act),
    .clr_i    (1'b0),
    .zero_o   (mr_zero),
    .active_o (mr_act)
  );

  tx_countdown #(.T(CHT_TIMEOUT)) u_cht (
    .clk      (clk),
    .nrst     (nrst),
    .load_i   (cht_load),
    .clr_i    (idle_fall),
    .zero_o   (cht_zero),
    .active_o (cht_act)
  );

  always_comb begin
    set_v           = '0;
    set_v[SRC_HB]   = rx_hb && !hbl_q;
    set_v[SRC_INVR] = inv_ok;
    set_v[SRC_INVO] = role_rise;
    set_v[SRC_CHT]  = cht_zero;
    set_v[SRC_MR]   = mr_zero;
    set_v[SRC_SOS]  = (rx_sos && iAmDestination)
                   || (low_E && !lowe_q);
    set_v[SRC_FWD]  = rx_data && iAmDestination;
  end

  always_comb begin
    hbl_d = hbl_q;
    if (rx_hb && !hbl_q) hbl_d = 1'b1;
    else if (rx_data)    hbl_d = 1'b0;
  end

  // A role drop while idle cancels the CH-only requests
  always_comb begin
    req = {iHaveData, flag_q};
    if (idle_fall) begin
      req[SRC_INVO] = 1'b0;
      req[SRC_CHT]  = 1'b0;
    end
  end

  assign win     = pick_src(req);
  assign nxt_cht = ({1'b0, idx_q} + 1'b1)
                 < {1'b0, neighborCount};

  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    idx_d    = idx_q;
    src_d    = src_q;
    clr_v    = '0;
    cht_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (idle_fall) begin
          clr_v[SRC_INVO] = 1'b1;
          clr_v[SRC_CHT]  = 1'b1;
        end
        if (|req) begin
          if (win != SRC_OWN) clr_v[win] = 1'b1;
          // CHT with an empty table is consumed silently
          if (!(win == SRC_CHT && neighborCount == '0)) begin
            src_d   = win;
            type_d  = src_type(win);
            idx_d   = '0;
            state_d = ST_PACK;
          end
        end
      end
      ST_PACK: state_d = ST_WAIT;
      ST_WAIT: if (pack_done) state_d = ST_TX;
      ST_TX: begin
        if (tx_ready) begin
          if (src_q == SRC_INVO) cht_load = 1'b1;
          if (type_q == PKT_CHT && nxt_cht) begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_PACK;
          end else begin
            type_d  = PKT_NONE;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Set wins over a same-cycle grant
  assign flag_d = (flag_q & ~clr_v) | set_v;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      type_q  <= PKT_NONE;
      idx_q   <= '0;
      src_q   <= SRC_OWN;
      flag_q  <= '0;
      hbl_q   <= 1'b0;
      role_q  <= 1'b0;
      lowe_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      idx_q   <= idx_d;
      src_q   <= src_d;
      flag_q  <= flag_d;
      hbl_q   <= hbl_d;
      role_q  <= role;
      lowe_q  <= low_E;
    end
  end

  assign pack_en    = (state_q == ST_PACK);
  assign tx_valid   = (state_q == ST_TX);
  assign busy       = (state_q != ST_IDLE);
  assign pack_type  = type_q;
  assign pack_index = idx_q;
  assign HBLock     = hbl_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// tb_tx_scheduler: directed and randomized checks of tx_scheduler
// with a packer/transmitter responder and an order-level model.
module tb_tx_scheduler;

  logic        clk = 1'b0;
  logic        nrst;
  logic        rx_valid;
  logic [2:0]  fPacketType;
  logic        iAmDestination;
  logic [15:0] hopsFromCH;
  logic        role;
  logic        low_E;
  logic        iHaveData;
  logic [5:0]  neighborCount;
  logic        pack_en;
  logic [2:0]  pack_type;
  logic [5:0]  pack_index;
  logic        pack_done = 1'b0;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        HBLock;
  logic        busy;

  tx_scheduler dut (
    .clk            (clk),
    .nrst           (nrst),
    .rx_valid       (rx_valid),
    .fPacketType    (fPacketType),
    .iAmDestination (iAmDestination),
    .hopsFromCH     (hopsFromCH),
    .role           (role),
    .low_E          (low_E),
    .iHaveData      (iHaveData),
    .neighborCount  (neighborCount),
    .pack_en        (pack_en),
    .pack_type      (pack_type),
    .pack_index     (pack_index),
    .pack_done      (pack_done),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .HBLock         (HBLock),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [2:0] t;
    logic [5:0] i;
  } rec_t;

  rec_t pe_q[$];
  rec_t hs_q[$];

  int tests = 0;
  int fails = 0;
  int done_dly = 1;
  int tx_dly = 0;
  bit tx_hold = 1'b0;
  int dcnt = 0;
  int txw = 0;
  bit mlock = 1'b0;

  always @(negedge clk)
    if (pack_en) pe_q.push_back('{cyc, pack_type, pack_index});

  always @(negedge clk) begin
    pack_done = 1'b0;
    if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) pack_done = 1'b1;
    end
    if (pack_en) dcnt = done_dly;
  end

  always @(negedge clk) begin
    tx_ready = 1'b0;
    if (tx_valid && !tx_hold) begin
      if (txw >= tx_dly) begin
        tx_ready = 1'b1;
        txw = 0;
        hs_q.push_back('{cyc, pack_type, pack_index});
      end else begin
        txw++;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rx(input logic [2:0] t, input bit d,
                    input logic [15:0] h, output int c);
    @(negedge clk);
    rx_valid = 1'b1;
    fPacketType = t;
    iAmDestination = d;
    hopsFromCH = h;
    c = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
    iAmDestination = 1'b0;
  endtask

  task automatic wait_pe(input string tag, input int n);
    int k = 0;
    while (pe_q.size() <= n && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_tmo"}, pe_q.size() > n, 1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    int quiet = 0;
    while (quiet < 4 && k < 400) begin
      @(negedge clk);
      k++;
      if (busy) quiet = 0;
      else quiet++;
    end
    chk(tag, quiet >= 4, 1);
  endtask

  // Model: OWN first (holds the channel), then each distinct pending
  // request once, in priority order HB, SOS, FWD.
  task automatic burst(input bit hb, input bit sr, input bit se,
                       input bit fw, input bit dn, input int reps,
                       input bit shuf, input bit hold20);
    int ev[$];
    logic [2:0] exp_t[$];
    int n, k, d, tmp;
    bit eh, es, ef;
    for (int r = 0; r < reps; r++) begin
      if (fw) ev.push_back(3);
      if (sr) ev.push_back(1);
      if (se) ev.push_back(2);
      if (hb) ev.push_back(0);
      if (dn) ev.push_back(4);
    end
    if (shuf)
      for (int i = ev.size() - 1; i > 0; i--) begin
        int j;
        j = $urandom_range(i, 0);
        tmp = ev[i];
        ev[i] = ev[j];
        ev[j] = tmp;
      end
    n = pe_q.size();
    eh = 0; es = 0; ef = 0;
    tx_hold = 1'b1;
    @(negedge clk);
    iHaveData = 1'b1;
    @(negedge clk);
    iHaveData = 1'b0;
    k = 0;
    while (!tx_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("own_txv", tx_valid, 1);
    if (hold20)
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        chk("hold_txv", tx_valid, 1);
        chk("hold_type", pack_type, 3'b101);
      end
    foreach (ev[i]) begin
      case (ev[i])
        0: begin
          if (!mlock) begin
            eh = 1;
            mlock = 1;
          end
          rx(3'b000, 0, 0, d);
        end
        1: begin
          es = 1;
          rx(3'b110, 1, 0, d);
        end
        2: begin
          es = 1;
          @(negedge clk);
          low_E = 1'b1;
          @(negedge clk);
          low_E = 1'b0;
        end
        3: begin
          ef = 1;
          mlock = 0;
          rx(3'b101, 1, 0, d);
        end
        default: begin
          mlock = 0;
          rx(3'b101, 0, 0, d);
        end
      endcase
    end
    tx_hold = 1'b0;
    wait_idle("burst_idle");
    exp_t.push_back(3'b101);
    if (eh) exp_t.push_back(3'b000);
    if (es) exp_t.push_back(3'b110);
    if (ef) exp_t.push_back(3'b101);
    chk("burst_cnt", pe_q.size() - n, exp_t.size());
    foreach (exp_t[i])
      chk("burst_type", pe_q[n + i].t, exp_t[i]);
    chk("burst_lock", HBLock, mlock);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, d, n, h0;
    nrst = 1'b0;
    rx_valid = 1'b0;
    fPacketType = 3'b000;
    iAmDestination = 1'b0;
    hopsFromCH = '0;
    role = 1'b0;
    low_E = 1'b0;
    iHaveData = 1'b0;
    neighborCount = 6'd3;
    repeat (3) @(negedge clk);
    chk("rst_pack_en", pack_en, 0);
    chk("rst_pack_type", pack_type, 3'b111);
    chk("rst_pack_index", pack_index, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_hblock", HBLock, 0);
    chk("rst_busy", busy, 0);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // Heartbeat ripple and lock
    n = pe_q.size();
    rx(3'b000, 0, 0, c);
    wait_pe("hb", n);
    chk("hb_cyc", pe_q[n].c, c + 2);
    chk("hb_type", pe_q[n].t, 3'b000);
    chk("hb_lock", HBLock, 1);
    mlock = 1;
    wait_idle("hb_idle");
    chk("hb_idle_type", pack_type, 3'b111);
    n = pe_q.size();
    rx(3'b000, 0, 0, c);
    repeat (10) @(negedge clk);
    chk("hb2_none", pe_q.size(), n);
    rx(3'b101, 0, 0, c);
    chk("hb_unlock", HBLock, 0);
    mlock = 0;
    rx(3'b000, 0, 0, c);
    wait_pe("hb3", n);
    chk("hb3_type", pe_q[n].t, 3'b000);
    mlock = 1;
    wait_idle("hb3_idle");
    chk("hb3_only", pe_q.size(), n + 1);

    // INV ripple and MR timer
    n = pe_q.size();
    rx(3'b010, 0, 16'd3, c);
    wait_pe("inv", n);
    chk("inv_cyc", pe_q[n].c, c + 2);
    chk("inv_type", pe_q[n].t, 3'b010);
    rx(3'b010, 0, 16'd2, d);
    wait_pe("inv2", n + 1);
    chk("inv2_type", pe_q[n + 1].t, 3'b010);
    wait_pe("mr", n + 2);
    chk("mr_type", pe_q[n + 2].t, 3'b011);
    chk("mr_cyc", pe_q[n + 2].c, c + 17);
    wait_idle("mr_idle");
    n = pe_q.size();
    rx(3'b010, 0, 16'd4, c);
    repeat (25) @(negedge clk);
    chk("inv4_none", pe_q.size(), n);

    // Role change, then CHT burst over three neighbours
    n = pe_q.size();
    h0 = hs_q.size();
    @(negedge clk);
    role = 1'b1;
    c = cyc;
    wait_pe("invo", n);
    chk("invo_cyc", pe_q[n].c, c + 2);
    chk("invo_type", pe_q[n].t, 3'b010);
    for (int i = 0; i < 3; i++) begin
      wait_pe("cht", n + 1 + i);
      chk("cht_type", pe_q[n + 1 + i].t, 3'b100);
      chk("cht_idx", pe_q[n + 1 + i].i, i);
    end
    chk("cht_cyc", pe_q[n + 1].c, hs_q[h0].c + 17);
    wait_idle("cht_idle");
    chk("cht_hs", hs_q.size() - h0, 4);
    chk("cht_cnt", pe_q.size() - n, 4);
    chk("cht_end_type", pack_type, 3'b111);
    @(negedge clk);
    role = 1'b0;
    repeat (3) @(negedge clk);

    // All pending together, plus a stalled transmitter
    burst(1, 1, 0, 1, 0, 2, 0, 1);

    // Randomized request mixes and handshake delays
    for (int it = 0; it < 12; it++) begin
      done_dly = $urandom_range(3, 1);
      tx_dly = $urandom_range(3, 0);
      burst($urandom_range(1, 0), $urandom_range(1, 0),
            $urandom_range(1, 0), $urandom_range(1, 0),
            $urandom_range(1, 0), $urandom_range(3, 1), 1, 0);
    end
    done_dly = 1;
    tx_dly = 0;

    // CHT grant with an empty neighbour table
    neighborCount = 6'd0;
    n = pe_q.size();
    @(negedge clk);
    role = 1'b1;
    wait_pe("nc0_invo", n);
    chk("nc0_invo_type", pe_q[n].t, 3'b010);
    repeat (40) @(negedge clk);
    chk("nc0_none", pe_q.size(), n + 1);
    chk("nc0_busy", busy, 0);
    role = 1'b0;
    repeat (3) @(negedge clk);

    // Reset while waiting on the packer mid-burst
    neighborCount = 6'd3;
    done_dly = 3;
    n = pe_q.size();
    @(negedge clk);
    role = 1'b1;
    wait_pe("rb", n + 2);
    chk("rb_idx", pe_q[n + 2].i, 1);
    chk("rb_wait_busy", busy, 1);
    chk("rb_wait_txv", tx_valid, 0);
    #1;
    nrst = 1'b0;
    role = 1'b0;
    #1;
    chk("rb_pack_en", pack_en, 0);
    chk("rb_pack_type", pack_type, 3'b111);
    chk("rb_pack_index", pack_index, 0);
    chk("rb_tx_valid", tx_valid, 0);
    chk("rb_hblock", HBLock, 0);
    chk("rb_busy", busy, 0);
    mlock = 0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    n = pe_q.size();
    repeat (40) @(negedge clk);
    chk("rb_no_pack", pe_q.size(), n);
    chk("rb_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
